// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch FSM state encoding and default program-counter width.
package fetch_pkg;
  localparam int PC_W_DEF = 16;
  typedef enum logic [2:0] {IDLE, OP, OPW, DEC, ARGW, ISSUE} fetch_state_t;
endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: byte-serial opcode/argument fetch FSM feeding a decoder and execute stage.
// Define IFETCH_CNT_EN to add the 32-bit instr_count handshake counter output.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] pmem_addr,
  output logic            pmem_rd,
  input  logic [7:0]      pmem_data,
  output logic [7:0]      opcode,
  input  logic [1:0]      argc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [15:0]     instr_arg,
  output logic [PC_W-1:0] instr_pc,
  input  logic            branch_taken,
`ifdef IFETCH_CNT_EN
  input  logic [15:0]     branch_offset,
  output logic [31:0]     instr_count
`else
  input  logic [15:0]     branch_offset
`endif
);
  fetch_state_t state, state_nx;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] off;
  logic [1:0] remaining;
  logic [1:0] argc_eff;
  logic hs;
  assign argc_eff = argc == 2'd3 ? 2'd2 : argc;
  assign off = PC_W'($signed(branch_offset));
  assign instr_valid = state == ISSUE;
  assign hs = instr_valid & instr_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // In ARGW the byte for pc arrives now, so the follow-on read targets pc+1.
  always_comb begin
    state_nx = state;
    pmem_rd = 1'b0;
    pmem_addr = state == ARGW ? pc + 1'b1 : pc;
    case (state)
      IDLE:  state_nx = OP;
      OP: begin
        pmem_rd = 1'b1;
        state_nx = OPW;
      end
      OPW:   state_nx = DEC;
      DEC: begin
        pmem_rd = argc_eff != 2'd0;
        state_nx = argc_eff != 2'd0 ? ARGW : ISSUE;
      end
      ARGW: begin
        pmem_rd = remaining != 2'd1;
        state_nx = remaining == 2'd1 ? ISSUE : ARGW;
      end
      ISSUE: state_nx = instr_ready ? OP : ISSUE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
      remaining <= '0;
      opcode <= '0;
      instr_arg <= '0;
      instr_pc <= '0;
    end else begin
      if (state == OP) instr_pc <= pc;
      if (state == OPW) begin
        opcode <= pmem_data;
        instr_arg <= '0;
        pc <= pc + 1'b1;
      end
      if (state == DEC) remaining <= argc_eff;
      if (state == ARGW) begin
        instr_arg <= {instr_arg[7:0], pmem_data};
        pc <= pc + 1'b1;
        remaining <= remaining - 1'b1;
      end
      if (hs && branch_taken) pc <= instr_pc + off;
    end
  end
`ifdef IFETCH_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) instr_count <= '0;
    else if (hs) instr_count <= instr_count + 32'd1;
`endif
endmodule
